// File: rtl/product_accumulator.sv
// Neuron pre-activation stage: registered adder tree over the per-lane products,
// then a per-group accumulator with bias, saturation and a sticky overflow flag.
module product_accumulator #(
   parameter int array_size    = 16,
   parameter int num_width     = 8,
   parameter int acc_width     = 32,
   parameter int beats_per_sum = 4
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                enable,
   input  logic                                in_valid,
   input  logic [2*num_width*array_size-1:0]   in_products,
   input  logic [acc_width-1:0]                bias,
   output logic                                out_valid,
   output logic [acc_width-1:0]                out_sum,
   output logic                                out_ovf
);

   localparam int PW   = 2 * num_width;
   localparam int LVLS = $clog2(array_size);
   localparam int TW   = PW + LVLS;
   localparam int CW   = (beats_per_sum > 1) ? $clog2(beats_per_sum) : 1;

   // Top bit of the result is the saturation flag; once set, the value is pinned to all-ones.
   function automatic logic [acc_width:0] sat_add(input logic [acc_width-1:0] a,
                                                  input logic [TW-1:0]        b,
                                                  input logic                 sat_in);
      logic [acc_width:0] s;
      s = {1'b0, a} + (acc_width+1)'(b);
      return (s[acc_width] || sat_in) ? {1'b1, {acc_width{1'b1}}} : s;
   endfunction

   logic [CW-1:0] r_beat_cnt;
   logic          w_accept;
   logic          w_first;
   logic          w_last;

   assign w_accept = enable & in_valid;
   assign w_first  = (r_beat_cnt == '0);
   assign w_last   = (r_beat_cnt == CW'(beats_per_sum - 1));

   always_ff @(posedge clk) begin
      if (reset)
         r_beat_cnt <= '0;
      else if (w_accept)
         r_beat_cnt <= w_last ? '0 : r_beat_cnt + 1'b1;
   end

   // Tree levels: level lvl holds array_size>>lvl sums, each one bit wider than its inputs.
   for (genvar lvl = 1; lvl <= LVLS; lvl++) begin : g_lvl
      localparam int N = array_size >> lvl;

      logic [PW+lvl-2:0]    w_src [2*N];
      logic                 w_vld_in;
      logic                 w_first_in;
      logic                 w_last_in;
      logic [acc_width-1:0] w_bias_in;

      logic [PW+lvl-1:0]    r_sum [N];
      logic                 r_vld;
      logic                 r_first;
      logic                 r_last;
      logic [acc_width-1:0] r_bias;

      if (lvl == 1) begin : g_src
         assign w_vld_in   = w_accept;
         assign w_first_in = w_first;
         assign w_last_in  = w_last;
         assign w_bias_in  = bias;
         for (genvar j = 0; j < 2*N; j++) begin : g_cp
            assign w_src[j] = in_products[j*PW +: PW];
         end
      end else begin : g_src
         assign w_vld_in   = g_lvl[lvl-1].r_vld;
         assign w_first_in = g_lvl[lvl-1].r_first;
         assign w_last_in  = g_lvl[lvl-1].r_last;
         assign w_bias_in  = g_lvl[lvl-1].r_bias;
         for (genvar j = 0; j < 2*N; j++) begin : g_cp
            assign w_src[j] = g_lvl[lvl-1].r_sum[j];
         end
      end

      always_ff @(posedge clk) begin
         if (reset)
            r_vld <= 1'b0;
         else if (enable)
            r_vld <= w_vld_in;
      end

      always_ff @(posedge clk) begin
         if (enable) begin
            r_first <= w_first_in;
            r_last  <= w_last_in;
            r_bias  <= w_bias_in;
            for (int j = 0; j < N; j++)
               r_sum[j] <= {1'b0, w_src[2*j]} + {1'b0, w_src[2*j+1]};
         end
      end
   end

   logic [TW-1:0]        w_tree_sum;
   logic                 w_tvld;
   logic                 w_tfirst;
   logic                 w_tlast;
   logic [acc_width-1:0] w_tbias;
   logic [acc_width:0]   w_res;
   logic [acc_width-1:0] r_acc;
   logic                 r_sat;

   assign w_tree_sum = g_lvl[LVLS].r_sum[0];
   assign w_tvld     = g_lvl[LVLS].r_vld;
   assign w_tfirst   = g_lvl[LVLS].r_first;
   assign w_tlast    = g_lvl[LVLS].r_last;
   assign w_tbias    = g_lvl[LVLS].r_bias;
   assign w_res      = sat_add(w_tfirst ? w_tbias : r_acc, w_tree_sum, r_sat);

   // Accumulate stage
   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc     <= '0;
         r_sat     <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_ovf   <= 1'b0;
      end else if (enable) begin
         out_valid <= 1'b0;
         if (w_tvld) begin
            if (w_tlast) begin
               out_sum   <= w_res[acc_width-1:0];
               out_ovf   <= w_res[acc_width];
               out_valid <= 1'b1;
               r_acc     <= '0;
               r_sat     <= 1'b0;
            end else begin
               r_acc <= w_res[acc_width-1:0];
               r_sat <= w_res[acc_width];
            end
         end
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: two instances (default, and 20-bit acc with one beat per group)
// share one stimulus stream and are compared every cycle against a group-sum model.
module tb_product_accumulator;

   localparam int AS = 16;
   localparam int NW = 8;
   localparam int PW = 16;
   localparam int L  = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          in_valid;
   logic [255:0]  in_products;
   logic [31:0]   bias;
   logic          ov0, of0, ov1, of1;
   logic [31:0]   os0;
   logic [19:0]   os1;

   always #5 clk = ~clk;

   product_accumulator #(.array_size(AS), .num_width(NW), .acc_width(32), .beats_per_sum(4)) u_dut0 (
      .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
      .in_products(in_products), .bias(bias),
      .out_valid(ov0), .out_sum(os0), .out_ovf(of0));

   product_accumulator #(.array_size(AS), .num_width(NW), .acc_width(20), .beats_per_sum(1)) u_dut1 (
      .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
      .in_products(in_products), .bias(bias[19:0]),
      .out_valid(ov1), .out_sum(os1), .out_ovf(of1));

   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;
   longint tick = 0;
   longint last_acc_cyc = 0;
   bit     started = 0;

   int     grp_n [2];
   longint grp_tot [2];
   bit     pend_v [2][64];
   longint pend_s [2][64];
   bit     pend_o [2][64];
   bit     exp_v [2];
   longint exp_s [2];
   bit     exp_o [2];
   int     pulse_cnt [2];
   longint hist_s [2][64];
   bit     hist_o [2][64];
   longint hist_c [2][64];

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic longint lane_sum(input logic [255:0] p);
      longint s = 0;
      for (int i = 0; i < AS; i++) s += longint'(p[i*PW +: PW]);
      return s;
   endfunction

   function automatic logic [255:0] fill(input logic [15:0] v);
      logic [255:0] p;
      for (int i = 0; i < AS; i++) p[i*PW +: PW] = v;
      return p;
   endfunction

   function automatic logic [255:0] ramp();
      logic [255:0] p;
      for (int i = 0; i < AS; i++) p[i*PW +: PW] = 16'(i);
      return p;
   endfunction

   // Group model: a group's result is min(bias + all its products, max); saturation is sticky,
   // and with non-negative addends that is the same as the true total exceeding max.
   // The result is due L enabled edges after the edge that accepts the group's last beat.
   initial begin
      logic         s_rst, s_en, s_iv;
      logic [255:0] s_p;
      logic [31:0]  s_b;
      longint       b, mx, tot;
      int           bps, idx;
      forever begin
         @(posedge clk);
         cyc++;
         s_rst = reset; s_en = enable; s_iv = in_valid; s_p = in_products; s_b = bias;
         if (s_rst) started = 1;
         if (!s_rst && s_en) tick++;
         for (int k = 0; k < 2; k++) begin
            exp_v[k] = 0;
            bps = (k == 0) ? 4 : 1;
            mx  = (k == 0) ? 64'd4294967295 : 64'd1048575;
            if (s_rst) begin
               grp_n[k] = 0; grp_tot[k] = 0; exp_s[k] = 0; exp_o[k] = 0;
               for (int t = 0; t < 64; t++) pend_v[k][t] = 0;
            end else if (s_en) begin
               if (s_iv) begin
                  b = (k == 0) ? longint'(s_b) : longint'(s_b & 32'h000F_FFFF);
                  if (grp_n[k] == 0) grp_tot[k] = b;
                  grp_tot[k] += lane_sum(s_p);
                  grp_n[k]++;
                  if (grp_n[k] == bps) begin
                     tot = grp_tot[k];
                     idx = int'((tick + L) % 64);
                     pend_v[k][idx] = 1;
                     pend_s[k][idx] = (tot > mx) ? mx : tot;
                     pend_o[k][idx] = (tot > mx);
                     grp_n[k] = 0;
                  end
               end
               idx = int'(tick % 64);
               if (pend_v[k][idx]) begin
                  exp_v[k] = 1; exp_s[k] = pend_s[k][idx]; exp_o[k] = pend_o[k][idx];
                  pend_v[k][idx] = 0;
               end
            end
         end
         if (!s_rst && s_en && s_iv) last_acc_cyc = cyc;
         #1;
         if (started) begin
            check("vld0", longint'(ov0), longint'(exp_v[0]));
            check("sum0", longint'(os0), exp_s[0]);
            check("ovf0", longint'(of0), longint'(exp_o[0]));
            check("vld1", longint'(ov1), longint'(exp_v[1]));
            check("sum1", longint'(os1), exp_s[1]);
            check("ovf1", longint'(of1), longint'(exp_o[1]));
         end
         if (ov0) begin
            hist_s[0][pulse_cnt[0] % 64] = longint'(os0); hist_o[0][pulse_cnt[0] % 64] = of0;
            hist_c[0][pulse_cnt[0] % 64] = cyc; pulse_cnt[0]++;
         end
         if (ov1) begin
            hist_s[1][pulse_cnt[1] % 64] = longint'(os1); hist_o[1][pulse_cnt[1] % 64] = of1;
            hist_c[1][pulse_cnt[1] % 64] = cyc; pulse_cnt[1]++;
         end
      end
   end

   task automatic drive(input bit rst, input bit en, input bit iv, input logic [255:0] p,
                        input logic [31:0] b);
      @(negedge clk);
      reset = rst; enable = en; in_valid = iv; in_products = p; bias = b;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 1, 0, '0, '0);
   endtask

   task automatic wait_pulse(input int k, input int target, input int budget, input string name);
      int n = 0;
      while (pulse_cnt[k] < target && n < budget) begin
         drive(0, 1, 0, '0, '0);
         n++;
      end
      check({name, "_arrived"}, longint'(pulse_cnt[k] >= target), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog pulses=%0d required=finish", pulse_cnt[0]);
      $fatal(1);
   end

   initial begin
      int p0, p1, np;
      logic [255:0] rp;
      reset = 1; enable = 0; in_valid = 0; in_products = '0; bias = '0;

      // All lanes 1, bias 0: 64; the pulse lands 4 edges after the accepting edge (5th cycle).
      drive(1, 1, 0, '0, '0);
      p0 = pulse_cnt[0];
      for (int i = 0; i < 4; i++) drive(0, 1, 1, fill(16'd1), 32'd0);
      wait_pulse(0, p0 + 1, 20, "t1");
      check("t1_sum", hist_s[0][p0 % 64], 64);
      check("t1_ovf", longint'(hist_o[0][p0 % 64]), 0);
      check("t1_lat", hist_c[0][p0 % 64] - last_acc_cyc, 4);
      idle(8);
      check("t1_count", pulse_cnt[0], p0 + 1);

      // Ramp lanes (120 per beat), bias 10, random gaps: 490.
      p0 = pulse_cnt[0];
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 1, ramp(), 32'd10);
         if (i < 3) idle($urandom_range(0, 3));
      end
      wait_pulse(0, p0 + 1, 20, "t2");
      check("t2_sum", hist_s[0][p0 % 64], 490);
      check("t2_ovf", longint'(hist_o[0][p0 % 64]), 0);
      check("t2_lat", hist_c[0][p0 % 64] - last_acc_cyc, 4);

      // Back-to-back groups: 133 then 199, four edges apart.
      idle(3);
      p0 = pulse_cnt[0];
      for (int i = 0; i < 4; i++) drive(0, 1, 1, fill(16'd2), 32'd5);
      for (int i = 0; i < 4; i++) drive(0, 1, 1, fill(16'd3), 32'd7);
      wait_pulse(0, p0 + 2, 20, "t3");
      check("t3_sumA", hist_s[0][p0 % 64], 133);
      check("t3_sumB", hist_s[0][(p0 + 1) % 64], 199);
      check("t3_gap", hist_c[0][(p0 + 1) % 64] - hist_c[0][p0 % 64], 4);

      // 20-bit accumulator, one beat per group: saturate, then a clean zero group.
      drive(1, 1, 0, '0, '0);
      p1 = pulse_cnt[1];
      drive(0, 1, 1, fill(16'hFFFF), 32'd100);
      drive(0, 1, 1, fill(16'h0000), 32'd0);
      wait_pulse(1, p1 + 2, 20, "t4");
      check("t4_sat_sum", hist_s[1][p1 % 64], 64'hFFFFF);
      check("t4_sat_ovf", longint'(hist_o[1][p1 % 64]), 1);
      check("t4_clr_sum", hist_s[1][(p1 + 1) % 64], 0);
      check("t4_clr_ovf", longint'(hist_o[1][(p1 + 1) % 64]), 0);

      // Stall for 3 cycles with beats in the tree: pulse moves out by exactly 3.
      drive(1, 1, 0, '0, '0);
      p0 = pulse_cnt[0];
      for (int i = 0; i < 4; i++) drive(0, 1, 1, fill(16'd1), 32'd0);
      idle(2);
      for (int i = 0; i < 3; i++) drive(0, 0, 1, fill(16'd7), 32'd3);
      wait_pulse(0, p0 + 1, 20, "t5");
      check("t5_sum", hist_s[0][p0 % 64], 64);
      check("t5_lat", hist_c[0][p0 % 64] - last_acc_cyc, 7);
      idle(8);
      check("t5_count", pulse_cnt[0], p0 + 1);

      // Partial group discarded by reset; a fresh group of four beats follows.
      drive(0, 1, 1, fill(16'd1), 32'd0);
      drive(0, 1, 1, fill(16'd1), 32'd0);
      drive(1, 1, 1, fill(16'd1), 32'd0);
      @(posedge clk); #2;
      check("t6_rst_vld", longint'(ov0), 0);
      check("t6_rst_sum", longint'(os0), 0);
      check("t6_rst_ovf", longint'(of0), 0);
      p0 = pulse_cnt[0];
      for (int i = 0; i < 4; i++) drive(0, 1, 1, fill(16'd1), 32'd0);
      wait_pulse(0, p0 + 1, 20, "t6");
      check("t6_sum", hist_s[0][p0 % 64], 64);
      idle(8);
      check("t6_count", pulse_cnt[0], p0 + 1);

      // Random traffic with stalls, gaps, occasional resets and saturating biases.
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < AS; i++)
            rp[i*PW +: PW] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
         drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6, rp,
               ($urandom_range(0, 7) == 0) ? 32'hFFFF_FF00 + 32'($urandom_range(0, 255))
                                           : 32'($urandom_range(0, 1000)));
      end
      idle(20);
      np = 0;
      for (int k = 0; k < 2; k++)
         for (int t = 0; t < 64; t++) np += int'(pend_v[k][t]);
      check("drain_pending", np, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
